// File: rtl/param_serializer.sv
// param_serializer
//   Loads a DATA_WIDTH-bit parallel word and shifts it out one bit per
//   ser_en tick, LSB- or MSB-first (chosen per word at load time). With
//   the SER_PARITY_EN macro defined, a parity bit (even or odd, chosen per
//   word) follows the data bits; without it no parity state or logic exists.
//
// Parameters
//   DATA_WIDTH  data bits per word (2..32)
//   IDLE_LEVEL  line level driven on out_data when not shifting
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   p_data      parallel word to serialize
//   data_valid  p_data valid; load when data_valid && data_ready
//   msb_first   bit order for the loaded word (1 = MSB first)
//   par_typ     parity type for the loaded word (1 = odd)
//   ser_en      bit-rate tick
//   data_ready  block can accept a word (IDLE and not in reset)
//   out_data    registered serial output
//   ser_done    one-clk pulse after the final bit of a word was driven
//   busy        a word is held (SHIFT or PARITY)
module param_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  msb_first,
    input  logic                  par_typ,
    input  logic                  ser_en,
    output logic                  data_ready,
    output logic                  out_data,
    output logic                  ser_done,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
`endif

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data,  w_data_nxt;
    logic                  r_msb,   w_msb_nxt;
    logic [CNT_W-1:0]      r_cnt,   w_cnt_nxt;
    logic                  r_out,   w_out_nxt;
    logic                  r_done,  w_done_nxt;
`ifdef SER_PARITY_EN
    logic                  r_par,   w_par_nxt;
`else
    logic                  w_unused_par;
    assign w_unused_par = par_typ;
`endif

    logic                  w_load;
    logic [CNT_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_sel;
    logic                  w_bit;

    assign data_ready = (r_state == S_IDLE) && !rst;
    assign busy       = (r_state != S_IDLE);
    assign out_data   = r_out;
    assign ser_done   = r_done;

    assign w_load = data_valid && data_ready;
    assign w_idx  = r_msb ? (LAST_IDX - r_cnt) : r_cnt;
    assign w_sel  = r_data >> w_idx;
    assign w_bit  = w_sel[0];

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_msb_nxt   = r_msb;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_done_nxt  = 1'b0;
`ifdef SER_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                // A load takes priority over the idle tick so the final bit of
                // the previous word stays on the line until the new first bit.
                if (w_load) begin
                    w_data_nxt  = p_data;
                    w_msb_nxt   = msb_first;
`ifdef SER_PARITY_EN
                    w_par_nxt   = par_typ;
`endif
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end else if (ser_en) begin
                    w_out_nxt = IDLE_LEVEL;
                end
            end
            S_SHIFT: begin
                if (ser_en) begin
                    w_out_nxt = w_bit;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
`ifdef SER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                if (ser_en) begin
                    w_out_nxt   = (^r_data) ^ r_par;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_msb   <= 1'b0;
            r_cnt   <= '0;
            r_out   <= IDLE_LEVEL;
            r_done  <= 1'b0;
`ifdef SER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_msb   <= w_msb_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
`ifdef SER_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_param_serializer.sv
// Two serializers run side by side: index 0 is DATA_WIDTH=8 / IDLE_LEVEL=1,
// index 1 is DATA_WIDTH=5 / IDLE_LEVEL=0. A load model pushes each accepted
// word's expected bit stream into a per-DUT queue; the monitor pops one entry
// per ser_en edge of a word in flight and checks every output every cycle.
module tb_param_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SER_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam logic [1:0] IDLE_LV = 2'b01;

    logic       rst;
    logic [1:0] dv, msb, par, en;
    logic [7:0] pd8;
    logic [4:0] pd5;
    logic [1:0] rdy, sout, done, bsy;

    param_serializer #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .p_data(pd8), .data_valid(dv[0]), .msb_first(msb[0]),
        .par_typ(par[0]), .ser_en(en[0]), .data_ready(rdy[0]), .out_data(sout[0]),
        .ser_done(done[0]), .busy(bsy[0]));

    param_serializer #(.DATA_WIDTH(5), .IDLE_LEVEL(1'b0)) u_dut5 (
        .clk(clk), .rst(rst), .p_data(pd5), .data_valid(dv[1]), .msb_first(msb[1]),
        .par_typ(par[1]), .ser_en(en[1]), .data_ready(rdy[1]), .out_data(sout[1]),
        .ser_done(done[1]), .busy(bsy[1]));

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];

    int total = 0;
    int bad   = 0;
    int accepts[2];
    int period[2];
    int cyc = 0;
    logic [1:0] m_out = IDLE_LV;

    logic        pre_rst = 1'b1;
    logic [1:0]  pre_dv  = '0;
    logic [1:0]  pre_en  = '0;
    logic [1:0]  pre_msb = '0;
    logic [1:0]  pre_par = '0;
    logic [31:0] pre_d[2];

    function automatic int qsize(input int k);
        return (k == 0) ? q8.size() : q5.size();
    endfunction

    task automatic qpush(input int k, input exp_t e);
        if (k == 0) q8.push_back(e);
        else        q5.push_back(e);
    endtask

    task automatic qpop(input int k, output exp_t e);
        if (k == 0) e = q8.pop_front();
        else        e = q5.pop_front();
    endtask

    task automatic qclear(input int k);
        if (k == 0) q8.delete();
        else        q5.delete();
    endtask

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %b expected %b", name, k, $time, act, exp);
        end
    endtask

    // Expected serial stream of one word: data bits in the chosen order,
    // then (parity build only) the parity of the word's ones count.
    task automatic load_word(input int k, input logic [31:0] d, input logic m, input logic p);
        int   w = (k == 0) ? 8 : 5;
        exp_t e;
        for (int i = 0; i < w; i++) begin
            int idx = m ? (w - 1 - i) : i;
            e.b    = d[idx];
            e.last = (i == w - 1) && !PAR_ON;
            qpush(k, e);
        end
        if (PAR_ON) begin
            e.b    = (($countones(d) % 2) == 1) ^ p;
            e.last = 1'b1;
            qpush(k, e);
        end
    endtask

    // Monitor / reference model: evaluates the edge that just happened from
    // inputs sampled at the previous negedge, then checks all outputs.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic exp_done;
            exp_t e;
            exp_done = 1'b0;
            if (!pre_rst) begin
                if (qsize(k) != 0) begin
                    if (pre_en[k]) begin
                        qpop(k, e);
                        m_out[k] = e.b;
                        exp_done = e.last;
                    end
                end else if (pre_dv[k]) begin
                    load_word(k, pre_d[k], pre_msb[k], pre_par[k]);
                    accepts[k]++;
                end else if (pre_en[k]) begin
                    m_out[k] = IDLE_LV[k];
                end
            end
            if (rst) begin
                qclear(k);
                m_out[k] = IDLE_LV[k];
                exp_done = 1'b0;
            end
            chk("out_data",   k, sout[k], m_out[k]);
            chk("ser_done",   k, done[k], exp_done);
            chk("data_ready", k, rdy[k],  (qsize(k) == 0) && !rst);
            chk("busy",       k, bsy[k],  qsize(k) != 0);
        end
        pre_rst  = rst;
        pre_dv   = dv;
        pre_en   = en;
        pre_msb  = msb;
        pre_par  = par;
        pre_d[0] = {24'b0, pd8};
        pre_d[1] = {27'b0, pd5};
    end

    // ser_en pacing: period 0 = random, N = one tick every N clocks.
    initial begin
        en = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                en[k] = (period[k] == 0) ? 1'($urandom_range(0, 1)) : ((cyc % period[k]) == 0);
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [31:0] d, input logic m, input logic p,
                        input bit hold_valid);
        int a0;
        int n = 0;
        tick(1);
        a0 = accepts[k];
        if (k == 0) pd8 = d[7:0];
        else        pd5 = d[4:0];
        msb[k] = m;
        par[k] = p;
        dv[k]  = 1'b1;
        while (accepts[k] == a0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (accepts[k] == a0) begin
            total++;
            bad++;
            $display("FAIL load_timeout dut%0d: got no load, expected one within 300 clks", k);
        end
        tick(1);
        if (!hold_valid) dv[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (qsize(k) != 0 && n < 500) begin
            tick(1);
            n++;
        end
        if (qsize(k) != 0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout dut%0d: got %0d bits pending, expected 0", k, qsize(k));
        end
        tick(3);
    endtask

    initial begin
        accepts[0] = 0;
        accepts[1] = 0;
        period[0]  = 1;
        period[1]  = 0;
        rst = 1'b1;
        dv  = '0;
        msb = '0;
        par = '0;
        pd8 = '0;
        pd5 = '0;
        tick(3);
        rst = 1'b0;
        tick(4);

        // bit order with a tick every clock; parity type exercised too
        send(0, 32'hC1, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 32'hC1, 1'b1, 1'b1, 1'b0);
        wait_idle(0);

        // slow ticks, data_valid and p_data churning while the word is in flight
        period[0] = 4;
        send(0, 32'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            dv[0] = 1'($urandom_range(0, 1));
            pd8   = 8'($urandom);
            tick(1);
        end
        dv[0] = 1'b0;
        wait_idle(0);

        // back-to-back words with data_valid held high
        period[0] = 1;
        send(0, 32'h01, 1'b0, 1'b0, 1'b1);
        send(0, 32'h80, 1'b0, 1'b0, 1'b0);
        wait_idle(0);

        // reset in the middle of a word
        send(0, 32'hC1, 1'b0, 1'b0, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);

        // narrow instance, idle level 0
        period[1] = 1;
        send(1, 32'h16, 1'b0, 1'b0, 1'b0);
        wait_idle(1);

        // randomized words on both instances
        for (int i = 0; i < 40; i++) begin
            int k = i % 2;
            period[k] = $urandom_range(0, 3);
            send(k, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                dv[k] = 1'b0;
                wait_idle(k);
            end
        end
        dv = '0;
        period[0] = 1;
        period[1] = 1;
        wait_idle(0);
        wait_idle(1);
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/param_serializer.md
PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per word (legal 2..32).
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b1, line level driven on out_data when not shifting.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 p_data  input  DATA_WIDTH  parallel word to serialize.
REQ-006 data_valid  input  1  p_data is valid; a load occurs when data_valid && data_ready at a clk edge.
REQ-007 msb_first  input  1  bit order, sampled at load: 0 = LSB first, 1 = MSB first.
REQ-008 par_typ  input  1  parity type, sampled at load: 0 = even, 1 = odd (ignored without SER_PARITY_EN).
REQ-009 ser_en  input  1  bit-rate tick; one output bit advances per clk edge with ser_en=1.
REQ-010 data_ready  output  1  block can accept a word.
REQ-011 out_data  output  1  registered serial output.
REQ-012 ser_done  output  1  registered one-clk pulse marking the final bit of a word.
REQ-013 busy  output  1  high while a word is held, in states SHIFT or PARITY.

Function
REQ-014 States SHALL be IDLE, SHIFT, and PARITY, with PARITY present only under SER_PARITY_EN.
REQ-015 data_ready SHALL be 1 exactly in IDLE with rst low, and 0 otherwise.
REQ-016 A load SHALL capture p_data, msb_first and par_typ into internal registers, clear the bit counter (width $clog2(DATA_WIDTH+1)), and move IDLE->SHIFT without changing out_data on the load edge, even if ser_en=1 that cycle.
REQ-017 In SHIFT, each edge with ser_en=1 SHALL drive the next bit onto out_data (index cnt for LSB-first, DATA_WIDTH-1-cnt for MSB-first) and increment cnt; edges with ser_en=0 SHALL hold all state.
REQ-018 The edge driving data bit cnt==DATA_WIDTH-1 SHALL go to PARITY (macro defined) or IDLE (macro undefined).
REQ-019 ser_done SHALL be 1 for exactly the one clk following the edge that drove the final bit of the word, and 0 at all other times.
REQ-020 In IDLE, an edge with ser_en=1 and no load SHALL drive IDLE_LEVEL; with ser_en=0, out_data SHALL hold, so the final bit lasts a full tick period.
REQ-021 In IDLE, a load and ser_en=1 on the same edge SHALL capture only, and out_data SHALL hold.
REQ-022 A load in IDLE while the final bit is still on out_data SHALL be legal, with its first bit replacing the final bit at the next ser_en edge (back-to-back, no idle gap).
REQ-023 data_valid in SHIFT or PARITY SHALL be ignored, and p_data changes after load SHALL not affect the word in flight.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, cnt=0, out_data=IDLE_LEVEL, ser_done=0, busy=0, data_ready=0, and clear the captured word, mode, and parity registers.
REQ-025 Reset mid-word SHALL abandon the word with no ser_done pulse, and data_ready SHALL be 1 on the first clk after rst deasserts.

Configuration
REQ-026 With macro SER_PARITY_EN defined, state PARITY SHALL exist, and the next ser_en edge after the last data bit SHALL drive the parity bit (XOR of the captured word, inverted when par_typ=1), then go to IDLE, with ser_done following the parity bit instead of the last data bit.
REQ-027 With SER_PARITY_EN undefined, no parity logic or state SHALL be synthesized, and each word SHALL be exactly DATA_WIDTH bits.

Verification
REQ-028 Reset: assert rst mid-word of 8'hC1 -> out_data=1, ser_done=0, busy=0 immediately; data_ready=1 one clk after release; no stale bits follow.
REQ-029 Order: DATA_WIDTH=8, ser_en=1 constant, 8'hC1: msb_first=0 -> 1,0,0,0,0,0,1,1; msb_first=1 -> 1,1,0,0,0,0,0,1; ser_done pulses one clk after the 8th bit.
REQ-030 Pacing: ser_en every 4th clk, 8'h5A -> each bit held 4 clks, ser_done exactly 1 clk wide, data_valid toggling mid-word ignored.
REQ-031 Back-to-back: data_valid held high with 8'h01 then 8'h80, LSB-first, ser_en=1 -> 16 contiguous bits 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 with no IDLE_LEVEL gap.
REQ-032 Parity (SER_PARITY_EN): 8'hC1 -> 9th bit 1 for par_typ=0 and 0 for par_typ=1, with ser_done after the 9th bit; without the macro -> 8 bits only.
REQ-033 Width: DATA_WIDTH=5, 5'b10110, LSB-first -> 0,1,1,0,1, then IDLE_LEVEL on the next ser_en edge.
